// File: rtl/fft_input_loader.sv
// Streams one frame of real samples into the four fft_top RAM banks in natural order,
// starts the transform, and holds off upstream until the transform reports completion.
module fft_input_loader #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 9,
   parameter int BANK_DEPTH = 512,
   parameter int N_POINTS   = 2048
) (
   input  logic              iCLK,
   input  logic              iRESET,
   input  logic              iVALID,
   input  logic [DATA_W-1:0] iSAMPLE,
   output logic              oREADY,
   output logic [DATA_W-1:0] oDATA,
   output logic [ADDR_W-1:0] oADDR_WR_0,
   output logic [ADDR_W-1:0] oADDR_WR_1,
   output logic [ADDR_W-1:0] oADDR_WR_2,
   output logic [ADDR_W-1:0] oADDR_WR_3,
   output logic              oWE_0,
   output logic              oWE_1,
   output logic              oWE_2,
   output logic              oWE_3,
   output logic              oSTART,
   input  logic              iFFT_RDY,
   output logic              oBUSY,
   output logic              oFRAME_DONE
);

   localparam int CNT_W = ADDR_W + 2;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_POINTS - 1);

   // The bank index is taken straight from the top two counter bits, so the geometry must be exact.
   if (BANK_DEPTH != (1 << ADDR_W) || N_POINTS != 4 * BANK_DEPTH) begin : g_param_check
      $error("fft_input_loader: BANK_DEPTH must be 2**ADDR_W and N_POINTS must be 4*BANK_DEPTH");
   end

   typedef enum logic [1:0] {
      S_LOAD,
      S_FLUSH,
      S_START,
      S_WAIT
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              rdy_q;
   logic              busy_q;
   logic [3:0]        we_q;
   logic [ADDR_W-1:0] addr_q;
   logic              accept;
   logic              rdy_rise;

   assign accept   = iVALID && (state == S_LOAD);
   assign rdy_rise = iFFT_RDY && !rdy_q;

   // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_nxt   = state;
      oREADY      = 1'b0;
      oSTART      = 1'b0;
      oFRAME_DONE = 1'b0;
      case (state)
         S_LOAD: begin
            oREADY = 1'b1;
            if (accept && cnt == LAST_CNT) state_nxt = S_FLUSH;
         end
         S_FLUSH: state_nxt = S_START;
         S_START: begin
            oSTART    = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (rdy_rise) begin
               oFRAME_DONE = 1'b1;
               state_nxt   = S_LOAD;
            end
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         // NOTE: the write-port data/address registers are reset because downstream sees them directly;
         // a real storage array would not be.
         state  <= S_LOAD;
         cnt    <= '0;
         rdy_q  <= 1'b0;
         busy_q <= 1'b0;
         we_q   <= '0;
         addr_q <= '0;
         oDATA  <= '0;
      end else begin
         state <= state_nxt;
         // Tracked in every state so a level already high when WAIT is entered is not seen as an edge.
         rdy_q <= iFFT_RDY;
         we_q  <= '0;
         if (accept) begin
            we_q   <= 4'b0001 << cnt[ADDR_W+1:ADDR_W];
            addr_q <= cnt[ADDR_W-1:0];
            oDATA  <= iSAMPLE;
            cnt    <= cnt + CNT_W'(1);
         end
         if (accept && cnt == '0) busy_q <= 1'b1;
         else if (oFRAME_DONE)    busy_q <= 1'b0;
      end
   end

   assign oWE_0      = we_q[0];
   assign oWE_1      = we_q[1];
   assign oWE_2      = we_q[2];
   assign oWE_3      = we_q[3];
   assign oADDR_WR_0 = addr_q;
   assign oADDR_WR_1 = addr_q;
   assign oADDR_WR_2 = addr_q;
   assign oADDR_WR_3 = addr_q;
   assign oBUSY      = busy_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: the stimulus side queues the expected bank/address/data
// of every accepted sample, and a negedge monitor matches each write-enable pulse against it.
module tb_fft_input_loader;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 9;
   localparam int BANK_DEPTH = 512;
   localparam int N_POINTS   = 2048;

   logic              iCLK     = 1'b0;
   logic              iRESET   = 1'b1;
   logic              iVALID   = 1'b0;
   logic [DATA_W-1:0] iSAMPLE  = '0;
   logic              iFFT_RDY = 1'b0;
   logic              oREADY, oSTART, oBUSY, oFRAME_DONE;
   logic              oWE_0, oWE_1, oWE_2, oWE_3;
   logic [DATA_W-1:0] oDATA;
   logic [ADDR_W-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;

   fft_input_loader #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_DEPTH(BANK_DEPTH), .N_POINTS(N_POINTS)
   ) dut (
      .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .iSAMPLE(iSAMPLE), .oREADY(oREADY),
      .oDATA(oDATA), .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1), .oADDR_WR_2(oADDR_WR_2),
      .oADDR_WR_3(oADDR_WR_3), .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
      .oSTART(oSTART), .iFFT_RDY(iFFT_RDY), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [3:0]        we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                stamp;
   } exp_t;

   exp_t sb[$];
   int   total = 0, bad = 0;
   int   neg_cnt = 0, start_cnt = 0, we_cnt = 0, exp_n = 0;
   logic [3:0] we_v;

   assign we_v = {oWE_3, oWE_2, oWE_1, oWE_0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every write pulse must match the oldest queued sample, one cycle after its accept.
   always @(negedge iCLK) begin
      exp_t e;
      neg_cnt++;
      if (oSTART === 1'b1) start_cnt++;
      if (|we_v) begin
         we_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_we", {60'd0, we_v}, 64'd0);
         end else begin
            e = sb.pop_front();
            check("write", {we_v, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3, oDATA},
                           {e.we, e.addr, e.addr, e.addr, e.addr, e.data});
            check("we_latency", neg_cnt, e.stamp + 1);
         end
      end
   end

   // Sample n of a frame lands in bank n/BANK_DEPTH at address n%BANK_DEPTH.
   task automatic send_samples(input int count, input bit gaps, input logic [DATA_W-1:0] seed);
      for (int i = 0; i < count; i++) begin
         logic [DATA_W-1:0] d;
         bit   accepted;
         exp_t e;
         if (gaps && $urandom_range(0, 1) == 1) begin
            iVALID = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge iCLK);
            #1;
         end
         d        = seed ^ DATA_W'(exp_n * 37);
         iVALID   = 1'b1;
         iSAMPLE  = d;
         accepted = 1'b0;
         for (int t = 0; t < 32 && !accepted; t++) begin
            @(negedge iCLK);
            accepted = (oREADY === 1'b1);
            @(posedge iCLK);
         end
         if (!accepted) begin
            check("accept_timeout", 64'd0, 64'd1);
            #1 iVALID = 1'b0;
            return;
         end
         e.we    = 4'(1 << (exp_n / BANK_DEPTH));
         e.addr  = ADDR_W'(exp_n % BANK_DEPTH);
         e.data  = d;
         e.stamp = neg_cnt;
         sb.push_back(e);
         exp_n++;
         #1;
      end
   endtask

   // Called just after the last accept: checks FLUSH/START/WAIT, backpressure and the done handshake.
   task automatic finish_frame(input int delay, input bit level);
      iVALID  = 1'b1;
      iSAMPLE = 16'hDEAD;
      @(negedge iCLK);
      check("start_in_flush", oSTART, 1'b0);
      check("ready_in_flush", oREADY, 1'b0);
      @(negedge iCLK);
      check("start_pulse", oSTART, 1'b1);
      check("ready_in_start", oREADY, 1'b0);
      check("we_in_start", we_v, 4'b0000);
      check("queue_drained", sb.size(), 0);
      @(negedge iCLK);
      check("start_single", oSTART, 1'b0);
      for (int c = 0; c < delay; c++) begin
         @(negedge iCLK);
         check("ready_in_wait", oREADY, 1'b0);
         check("done_early", oFRAME_DONE, 1'b0);
      end
      check("busy_in_wait", oBUSY, 1'b1);
      if (level) begin
         @(posedge iCLK);
         #1 iFFT_RDY = 1'b0;
         @(negedge iCLK);
         check("done_on_fall", oFRAME_DONE, 1'b0);
      end
      @(posedge iCLK);
      #1 iFFT_RDY = 1'b1;
      iVALID = 1'b0;
      @(negedge iCLK);
      check("done_pulse", oFRAME_DONE, 1'b1);
      check("ready_at_done", oREADY, 1'b0);
      @(negedge iCLK);
      check("done_single", oFRAME_DONE, 1'b0);
      check("ready_after_done", oREADY, 1'b1);
      check("busy_cleared", oBUSY, 1'b0);
      @(posedge iCLK);
      #1 iFFT_RDY = 1'b0;
   endtask

   task automatic run_frame(input bit gaps, input logic [DATA_W-1:0] seed, input int delay, input bit level);
      int s0, w0;
      s0    = start_cnt;
      w0    = we_cnt;
      exp_n = 0;
      if (level) iFFT_RDY = 1'b1;
      send_samples(N_POINTS, gaps, seed);
      finish_frame(delay, level);
      check("we_count", we_cnt - w0, N_POINTS);
      check("start_count", start_cnt - s0, 1);
   endtask

   initial begin
      // T1: reset held with valid asserted.
      iVALID  = 1'b1;
      iSAMPLE = 16'h1234;
      repeat (3) begin
         @(posedge iCLK);
         @(negedge iCLK);
         check("rst_we", we_v, 4'b0000);
         check("rst_ready", oREADY, 1'b1);
         check("rst_start", oSTART, 1'b0);
         check("rst_busy", oBUSY, 1'b0);
      end
      check("rst_data_addr", {oDATA, oADDR_WR_0, oADDR_WR_3}, 64'd0);
      @(posedge iCLK);
      #1 iRESET = 1'b0;
      iVALID = 1'b0;

      // T2: back-to-back frame.
      run_frame(1'b0, 16'hA5C3, 5, 1'b0);
      // T3 + T4: stalled frame, backpressure in WAIT, ready raised 50 cycles after start.
      run_frame(1'b1, 16'h5A3C, 50, 1'b0);
      // T5: ready already high before start must fall and rise again.
      run_frame(1'b0, 16'hFFFF, 10, 1'b1);

      // T6: reset after 700 samples.
      begin
         int w0;
         w0    = we_cnt;
         exp_n = 0;
         send_samples(700, 1'b0, 16'h0F0F);
         iRESET = 1'b1;
         iVALID = 1'b1;
         @(negedge iCLK);
         @(negedge iCLK);
         check("mid_rst_we_stop", we_v, 4'b0000);
         check("mid_rst_we_count", we_cnt - w0, 700);
         check("mid_rst_queue", sb.size(), 0);
         check("mid_rst_ready", oREADY, 1'b1);
         check("mid_rst_busy", oBUSY, 1'b0);
         @(posedge iCLK);
         #1 iRESET = 1'b0;
         iVALID = 1'b0;
      end
      run_frame(1'b0, 16'h3C96, 3, 1'b0);

      repeat (3) @(posedge iCLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
